vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen_pkg.sv | 30 +++
 rtl/vga_sync_gen_delay_line.sv | 43 ++++
 rtl/vga_sync_gen.sv | 130 +++++++++++++
 tb/tb_vga_sync_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants and types for the sync generator and its consumers.
// Default values describe 640x480 at 60 Hz with a 25.175 MHz pixel clock.
package vga_sync_gen_pkg;

  localparam int CNT_W     = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_H_TOT  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic nvis;
  } sync_bus_t;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic wrap);
    return wrap ? '0 : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_gen_delay_line.sv
// Fixed-depth shift register; every stage loads RESET_VAL on a synchronous active-low reset.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("vga_delay_line: DEPTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: undelayed pixel coordinates and strobes for address generation,
// plus sync/visibility delayed by PIPE_DELAY clocks to match the pixel fetch latency.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_VIS        = DEF_H_VIS,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_VIS        = DEF_V_VIS,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int SYNC_ACTIVE  = 0,
  parameter int PIPE_DELAY   = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk,
  input  logic             nRst,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             visRaw,
  output logic             lineStart,
  output logic             frameStart,
  output logic             blink,
  output logic             hSync,
  output logic             vSync,
  output logic             nVis
);

  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BLINK_W = (BLINK_FRAMES > 16) ? $clog2(BLINK_FRAMES) : 4;

  generate
    if (H_TOT > CNT_LIMIT || V_TOT > CNT_LIMIT) begin : g_bad_tot
      $error("vga_sync_gen: H_TOT and V_TOT must not exceed 1024");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_pipe
      $error("vga_sync_gen: PIPE_DELAY must be within 1..8");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("vga_sync_gen: BLINK_FRAMES must be at least 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0]   H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0]   V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0]   H_VIS_C    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0]   V_VIS_C    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0]   HS_FIRST   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0]   HS_LAST    = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0]   VS_FIRST   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0]   VS_LAST    = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic               SYNC_ON    = (SYNC_ACTIVE != 0);
  localparam sync_bus_t          SYNC_IDLE  = '{hsync: ~SYNC_ON, vsync: ~SYNC_ON, nvis: 1'b1};

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               h_wrap, v_wrap, frame_wrap;
  logic               vis_raw, hs_active, vs_active;
  sync_bus_t          sync_raw, sync_dly;

  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    frame_wrap  = h_wrap && v_wrap;
    h_cnt_d     = cnt_next(h_cnt_q, h_wrap);
    v_cnt_d     = h_wrap ? cnt_next(v_cnt_q, v_wrap) : v_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    // Blink phase advances only on complete frames, so a mid-frame reset never counts.
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    vis_raw        = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    hs_active      = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    vs_active      = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    sync_raw.hsync = hs_active ? SYNC_ON : ~SYNC_ON;
    sync_raw.vsync = vs_active ? SYNC_ON : ~SYNC_ON;
    sync_raw.nvis  = ~vis_raw;
  end

  vga_delay_line #(
    .WIDTH     ($bits(sync_bus_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (nRst),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign hCount     = h_cnt_q;
  assign vCount     = v_cnt_q;
  assign visRaw     = vis_raw;
  assign lineStart  = (h_cnt_q == '0);
  assign frameStart = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign blink      = blink_q;
  assign hSync      = sync_dly.hsync;
  assign vSync      = sync_dly.vsync;
  assign nVis       = sync_dly.nvis;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, PIPE_DELAY=1/positive-sync variant,
// and a shrunken-timing instance (16x8 clocks per frame) for frame-level and blink checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #20 clk = ~clk;

  logic [9:0] def_h, def_v, p1_h, p1_v, sm_h, sm_v;
  logic def_vis, def_ls, def_fs, def_blink, def_hs, def_vs, def_nvis;
  logic p1_vis, p1_ls, p1_fs, p1_blink, p1_hs, p1_vs, p1_nvis;
  logic sm_vis, sm_ls, sm_fs, sm_blink, sm_hs, sm_vs, sm_nvis;

  vga_sync_gen u_def (
    .clk(clk), .nRst(nrst), .hCount(def_h), .vCount(def_v), .visRaw(def_vis),
    .lineStart(def_ls), .frameStart(def_fs), .blink(def_blink),
    .hSync(def_hs), .vSync(def_vs), .nVis(def_nvis)
  );

  vga_sync_gen #(.PIPE_DELAY(1), .SYNC_ACTIVE(1)) u_p1 (
    .clk(clk), .nRst(nrst), .hCount(p1_h), .vCount(p1_v), .visRaw(p1_vis),
    .lineStart(p1_ls), .frameStart(p1_fs), .blink(p1_blink),
    .hSync(p1_hs), .vSync(p1_vs), .nVis(p1_nvis)
  );

  vga_sync_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .BLINK_FRAMES(16)
  ) u_sm (
    .clk(clk), .nRst(nrst), .hCount(sm_h), .vCount(sm_v), .visRaw(sm_vis),
    .lineStart(sm_ls), .frameStart(sm_fs), .blink(sm_blink),
    .hSync(sm_hs), .vSync(sm_vs), .nVis(sm_nvis)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    nrst = 1'b0;
    step(1);
    nrst = 1'b1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      vec_cnt++;
      if ({def_hs, def_vs, def_nvis, def_blink} !== 4'b1110 || def_h !== 10'd0 || def_v !== 10'd0) begin
        err_cnt++;
        $display("FAIL reset_hold_def: got hs=%b vs=%b nvis=%b blink=%b h=%0d v=%0d, expected 1 1 1 0 0 0",
                 def_hs, def_vs, def_nvis, def_blink, def_h, def_v);
      end
      vec_cnt++;
      if ({p1_hs, p1_vs, p1_nvis} !== 3'b001) begin
        err_cnt++;
        $display("FAIL reset_hold_p1: got hs=%b vs=%b nvis=%b, expected 0 0 1", p1_hs, p1_vs, p1_nvis);
      end
    end
    nrst = 1'b1;
    vec_cnt++;
    if (def_h !== 10'd0 || def_v !== 10'd0 || def_fs !== 1'b1 || def_ls !== 1'b1 || def_vis !== 1'b1) begin
      err_cnt++;
      $display("FAIL release_first_cycle: got h=%0d v=%0d fs=%b ls=%b vis=%b, expected 0 0 1 1 1",
               def_h, def_v, def_fs, def_ls, def_vis);
    end
    step(1);
    vec_cnt++;
    if (def_h !== 10'd1 || def_nvis !== 1'b1 || def_fs !== 1'b0) begin
      err_cnt++;
      $display("FAIL release_plus1: got h=%0d nvis=%b fs=%b, expected 1 1 0", def_h, def_nvis, def_fs);
    end
    vec_cnt++;
    if (p1_nvis !== 1'b0) begin
      err_cnt++;
      $display("FAIL release_plus1_p1_nvis: got %b, expected 0", p1_nvis);
    end
    step(1);
    vec_cnt++;
    if (def_h !== 10'd2 || def_nvis !== 1'b0) begin
      err_cnt++;
      $display("FAIL release_plus2: got h=%0d nvis=%b, expected 2 0", def_h, def_nvis);
    end
  endtask

  task automatic test_line;
    int bad_h = 0, bad_v = 0, ls_cnt = 0;
    int hs_cnt = 0, hs_first = -1, hs_last = -1;
    int nv_cnt = 0, nv_first = -1, nv_last = -1;
    do_reset();
    for (int i = 0; i <= 800; i++) begin
      if (def_h !== 10'(i % 800)) bad_h++;
      if (def_v !== ((i < 800) ? 10'd0 : 10'd1)) bad_v++;
      if (i < 800 && def_ls === 1'b1) ls_cnt++;
      if (def_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(def_h);
        hs_last = int'(def_h);
      end
      if (def_nvis === 1'b0) begin
        nv_cnt++;
        if (nv_first < 0) nv_first = int'(def_h);
        nv_last = int'(def_h);
      end
      step(1);
    end
    vec_cnt++;
    if (bad_h != 0) begin err_cnt++; $display("FAIL line_hcount_seq: got %0d bad cycles, expected 0", bad_h); end
    vec_cnt++;
    if (bad_v != 0) begin err_cnt++; $display("FAIL line_vcount_wrap: got %0d bad cycles, expected 0", bad_v); end
    vec_cnt++;
    if (ls_cnt != 1) begin err_cnt++; $display("FAIL line_start_cnt: got %0d, expected 1", ls_cnt); end
    vec_cnt++;
    if (hs_cnt != 96 || hs_first != 658 || hs_last != 753) begin
      err_cnt++;
      $display("FAIL line_hsync: got cnt=%0d first=%0d last=%0d, expected 96 658 753", hs_cnt, hs_first, hs_last);
    end
    vec_cnt++;
    if (nv_cnt != 640 || nv_first != 2 || nv_last != 641) begin
      err_cnt++;
      $display("FAIL line_nvis: got cnt=%0d first=%0d last=%0d, expected 640 2 641", nv_cnt, nv_first, nv_last);
    end
  endtask

  task automatic test_pipe1_polarity;
    int hs_cnt = 0, hs_first = -1, hs_last = -1;
    int nv_cnt = 0, nv_first = -1, nv_last = -1;
    do_reset();
    for (int i = 0; i <= 800; i++) begin
      if (p1_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(p1_h);
        hs_last = int'(p1_h);
      end
      if (p1_nvis === 1'b0) begin
        nv_cnt++;
        if (nv_first < 0) nv_first = int'(p1_h);
        nv_last = int'(p1_h);
      end
      step(1);
    end
    vec_cnt++;
    if (hs_cnt != 96 || hs_first != 657 || hs_last != 752) begin
      err_cnt++;
      $display("FAIL p1_hsync: got cnt=%0d first=%0d last=%0d, expected 96 657 752", hs_cnt, hs_first, hs_last);
    end
    vec_cnt++;
    if (nv_cnt != 640 || nv_first != 1 || nv_last != 640) begin
      err_cnt++;
      $display("FAIL p1_nvis: got cnt=%0d first=%0d last=%0d, expected 640 1 640", nv_cnt, nv_first, nv_last);
    end
    vec_cnt++;
    if (p1_vs !== 1'b0) begin err_cnt++; $display("FAIL p1_vsync_idle: got %b, expected 0", p1_vs); end
  endtask

  task automatic test_frame;
    int vs_cnt = 0, vs_h = -1, vs_v = -1, fs_cnt = 0, fs_last = -1;
    int nv_cnt = 0, nv_line0 = 0, nv_blank = 0, ls_cnt = 0;
    do_reset();
    for (int i = 0; i <= 128; i++) begin
      if (sm_vs === 1'b0) begin
        vs_cnt++;
        if (vs_h < 0) begin vs_h = int'(sm_h); vs_v = int'(sm_v); end
      end
      if (sm_fs === 1'b1) begin fs_cnt++; fs_last = i; end
      if (i < 128) begin
        if (sm_ls === 1'b1) ls_cnt++;
        if (sm_nvis === 1'b0) begin
          nv_cnt++;
          if (sm_v == 10'd0) nv_line0++;
          if (sm_v >= 10'd4) nv_blank++;
        end
      end
      step(1);
    end
    vec_cnt++;
    if (vs_cnt != 32 || vs_h != 2 || vs_v != 5) begin
      err_cnt++;
      $display("FAIL frame_vsync: got cnt=%0d start h=%0d v=%0d, expected 32 2 5", vs_cnt, vs_h, vs_v);
    end
    vec_cnt++;
    if (fs_cnt != 2 || fs_last != 128) begin
      err_cnt++;
      $display("FAIL frame_length: got strobes=%0d second_at=%0d, expected 2 128", fs_cnt, fs_last);
    end
    vec_cnt++;
    if (ls_cnt != 8) begin err_cnt++; $display("FAIL frame_line_strobes: got %0d, expected 8", ls_cnt); end
    vec_cnt++;
    if (nv_cnt != 32 || nv_line0 != 8 || nv_blank != 0) begin
      err_cnt++;
      $display("FAIL frame_nvis: got total=%0d line0=%0d blank=%0d, expected 32 8 0", nv_cnt, nv_line0, nv_blank);
    end
  endtask

  task automatic test_blink;
    int tog = 0, t1 = -1, t2 = -1;
    logic prev;
    do_reset();
    vec_cnt++;
    if (sm_blink !== 1'b0) begin err_cnt++; $display("FAIL blink_initial: got %b, expected 0", sm_blink); end
    prev = sm_blink;
    for (int i = 1; i <= 33 * 128 + 10; i++) begin
      step(1);
      if (sm_blink !== prev) begin
        tog++;
        if (tog == 1) t1 = i;
        if (tog == 2) t2 = i;
      end
      prev = sm_blink;
    end
    vec_cnt++;
    if (tog != 2 || t1 != 2048 || t2 != 4096) begin
      err_cnt++;
      $display("FAIL blink_toggles: got count=%0d at %0d,%0d, expected 2 at 2048,4096", tog, t1, t2);
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    step(1900);
    vec_cnt++;
    if (def_h !== 10'd300 || def_v !== 10'd2 || sm_vs !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_pre: got h=%0d v=%0d sm_vs=%b, expected 300 2 0", def_h, def_v, sm_vs);
    end
    nrst = 1'b0;
    step(1);
    vec_cnt++;
    if (def_h !== 10'd0 || def_v !== 10'd0 || def_nvis !== 1'b1 || def_hs !== 1'b1 || def_vs !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_def: got h=%0d v=%0d nvis=%b hs=%b vs=%b, expected 0 0 1 1 1",
               def_h, def_v, def_nvis, def_hs, def_vs);
    end
    vec_cnt++;
    if (sm_h !== 10'd0 || sm_v !== 10'd0 || sm_vs !== 1'b1 || sm_nvis !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_small: got h=%0d v=%0d vs=%b nvis=%b, expected 0 0 1 1", sm_h, sm_v, sm_vs, sm_nvis);
    end
    nrst = 1'b1;
    vec_cnt++;
    if (def_fs !== 1'b1 || sm_fs !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_framestart: got def=%b small=%b, expected 1 1", def_fs, sm_fs);
    end
    step(1);
    vec_cnt++;
    if (def_nvis !== 1'b1) begin err_cnt++; $display("FAIL midrst_nvis_plus1: got %b, expected 1", def_nvis); end
    step(1);
    vec_cnt++;
    if (def_h !== 10'd2 || def_nvis !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_nvis_plus2: got h=%0d nvis=%b, expected 2 0", def_h, def_nvis);
    end
    step(655);
    vec_cnt++;
    if (def_h !== 10'd657 || def_hs !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_hsync_657: got h=%0d hs=%b, expected 657 1", def_h, def_hs);
    end
    step(1);
    vec_cnt++;
    if (def_h !== 10'd658 || def_hs !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_hsync_658: got h=%0d hs=%b, expected 658 0", def_h, def_hs);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_pipe1_polarity();
    test_frame();
    test_blink();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
